// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the round-robin memory controller.
package mem_ctrl_pkg;

  // Controller states: idle/arbitrating, streaming a read, streaming a write.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  // UART location; this address and the next word are treated as IO.
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  // Addresses are widened to 64 bits so one function serves any ADDR_WIDTH.
  function automatic logic is_io_addr(input logic [63:0] addr, input logic [63:0] base);
    return (addr == base) || (addr == base + 64'd4);
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arbiter.sv
// Round-robin requester selection; search begins one past the last grant.
module rr_arbiter #(
  parameter int N_PORTS = 3
) (
  input  logic [N_PORTS-1:0]         req_i,
  input  logic [$clog2(N_PORTS)-1:0] last_i,
  output logic [N_PORTS-1:0]         grant_o,
  output logic                       valid_o
);

  // Walk the ports in rotated order and take the first requester found.
  always_comb begin
    int  j;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 1; i <= N_PORTS; i++) begin
      j = int'(last_i) + i;
      if (j >= N_PORTS) j = j - N_PORTS;
      if (!found && req_i[j]) begin
        grant_o[j] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/mem_ctrl_rr.sv
// Multi-port byte-serial RAM controller with round-robin arbitration,
// flush abort of reads and UART back-pressure on IO writes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transfer; arbitrate among eligible requesters
// S_READ  | address streaming out, bytes captured two edges later
// S_WRITE | one byte per edge driven with MCRAM_wr high
module mem_ctrl_rr #(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  N_PORTS    = 3,
  parameter int                  MAX_BYTES  = 8,
  parameter logic [N_PORTS-1:0]  FLUSHABLE  = '1,
  parameter logic [31:0]         IO_BASE    = mem_ctrl_pkg::IO_BASE
) (
  input  logic                                       Sys_clk,
  input  logic                                       Sys_rst,
  input  logic                                       Sys_rdy,
  input  logic                                       flush,
  input  logic [7:0]                                 RAMMC_data,
  input  logic                                       io_buffer_full,
  output logic [7:0]                                 MCRAM_data,
  output logic [ADDR_WIDTH-1:0]                      MCRAM_addr,
  output logic                                       MCRAM_wr,
  input  logic [N_PORTS-1:0]                         req_en,
  input  logic [N_PORTS-1:0]                         req_wr,
  input  logic [N_PORTS*$clog2(MAX_BYTES+1)-1:0]     req_len,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]              req_addr,
  input  logic [N_PORTS*8*MAX_BYTES-1:0]             req_wdata,
  output logic [N_PORTS-1:0]                         done,
  output logic [8*MAX_BYTES-1:0]                     rdata
);

  import mem_ctrl_pkg::*;

  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam int PW = $clog2(N_PORTS);
  localparam int DW = 8 * MAX_BYTES;

  state_e                state_q, state_d;
  logic [PW-1:0]         port_q, port_d;
  logic [PW-1:0]         last_q, last_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mwr_q, mwr_d;
  logic [7:0]            mdata_q, mdata_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         buf_q, buf_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [N_PORTS-1:0]    done_q, done_d;

  logic [ADDR_WIDTH-1:0] p_addr  [N_PORTS];
  logic [LW-1:0]         p_len   [N_PORTS];
  logic [DW-1:0]         p_wdata [N_PORTS];
  logic [N_PORTS-1:0]    p_io;
  logic [N_PORTS-1:0]    elig;
  logic [N_PORTS-1:0]    gnt;
  logic                  gnt_valid;
  logic [PW-1:0]         gnt_idx;
  logic [LW-1:0]         cnt_next;
  logic [LW-1:0]         cap_idx;
  logic [LW-1:0]         sel_len;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign p_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign p_len[g]   = req_len[g*LW +: LW];
    assign p_wdata[g] = req_wdata[g*DW +: DW];
    assign p_io[g]    = is_io_addr(64'(p_addr[g]), 64'(IO_BASE));
  end

  // A port competes only if it is not mid-pulse, not a blocked UART write
  // and not a read that the current flush would throw away.
  always_comb begin
    elig = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      elig[p] = req_en[p] & ~done_q[p]
              & ~(req_wr[p] & p_io[p] & io_buffer_full)
              & ~(flush & ~req_wr[p] & FLUSHABLE[p]);
    end
  end

  rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .req_i   (elig),
    .last_i  (last_q),
    .grant_o (gnt),
    .valid_o (gnt_valid)
  );

  // One-hot grant to port index.
  always_comb begin
    gnt_idx = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) gnt_idx = PW'(p);
    end
  end

  // Next-state and datapath: cnt_q counts edges since the grant edge.
  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    last_d   = last_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    mwr_d    = mwr_q;
    mdata_d  = mdata_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    done_d   = '0;
    cnt_next = cnt_q + LW'(1);
    cap_idx  = cnt_q - LW'(1);
    sel_len  = p_len[gnt_idx];
    if (sel_len == '0) sel_len = LW'(1);
    if (req_wr[gnt_idx] && p_io[gnt_idx]) sel_len = LW'(1);

    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          port_d = gnt_idx;
          last_d = gnt_idx;
          len_d  = sel_len;
          cnt_d  = '0;
          addr_d = p_addr[gnt_idx];
          if (req_wr[gnt_idx]) begin
            state_d = S_WRITE;
            wdata_d = p_wdata[gnt_idx];
            mwr_d   = 1'b1;
            mdata_d = p_wdata[gnt_idx][7:0];
          end else begin
            state_d = S_READ;
            buf_d   = '0;
          end
        end
      end

      S_READ: begin
        if (flush && FLUSHABLE[port_q]) begin
          state_d = S_IDLE;
          addr_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_next;
          if (cnt_next < len_q) addr_d = addr_q + ADDR_WIDTH'(1);
          // RAM returns data two edges after the address is presented.
          if (cnt_q != '0) buf_d[8*cap_idx +: 8] = RAMMC_data;
          if (cnt_q == len_q) begin
            rdata_d        = buf_d;
            done_d[port_q] = 1'b1;
            state_d        = S_IDLE;
            addr_d         = '0;
            cnt_d          = '0;
          end
        end
      end

      S_WRITE: begin
        cnt_d = cnt_next;
        if (cnt_next < len_q) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          mdata_d = wdata_q[8*cnt_next +: 8];
        end else begin
          mwr_d          = 1'b0;
          addr_d         = '0;
          done_d[port_q] = 1'b1;
          state_d        = S_IDLE;
          cnt_d          = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        mwr_d   = 1'b0;
        addr_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; everything freezes while Sys_rdy is low.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state_q <= S_IDLE;
      port_q  <= '0;
      last_q  <= PW'(N_PORTS - 1);
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      mwr_q   <= 1'b0;
      mdata_q <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      done_q  <= '0;
    end else if (Sys_rdy) begin
      state_q <= state_d;
      port_q  <= port_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      mwr_q   <= mwr_d;
      mdata_q <= mdata_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign MCRAM_addr = addr_q;
  assign MCRAM_wr   = mwr_q;
  assign MCRAM_data = mdata_q;
  assign done       = done_q;
  assign rdata      = rdata_q;

endmodule
